stim_mem_responder: RTL and testbench
=====================================

Name: stim_mem_responder

Overview:
- Memory-side responder for the stimulus/driver request interface.
- Accepts single-word read/write requests over a req/ack handshake and holds a small synchronous word store (default 8 x 24 bit).
- Supports an internal auto-incrementing pointer mode with a wrap-out flag for sequential sweeps.
- Sits between a testbench stimulus initiator and any consumer of its read data.

Parameters:
- DATA_W, 24, word width in bits.
- ADDR_W, 3, address width; depth = 2**ADDR_W words, so every address is in range.

Ports:
- clk  input  1  single clock, all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  1  request valid; held high by the initiator until ack.
- write  input  1  1 = write, 0 = read; sampled with req.
- use_ptr  input  1  1 = use the internal pointer as the address (addr ignored); sampled with req.
- addr  input  ADDR_W  explicit request address, or pointer load value.
- wdata  input  DATA_W  write data; sampled with req.
- ptr_load  input  1  loads the pointer from addr; honoured in IDLE only when req=0.
- ack  output  1  one-cycle completion pulse.
- rdata  output  DATA_W  read data; valid only while ack=1 on a read, 0 otherwise.
- wrap  output  1  one-cycle pulse, coincident with ack, when the pointer wraps from max to 0.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - ack=0, rdata=0, wrap=0, busy=0.
  - State = IDLE, pointer = 0, all memory words = 0.
  - Reset mid-transaction abandons the transaction: no ack, no write commit if not yet committed.
- FSM states:
  - IDLE: on req=1, latch write/use_ptr/addr/wdata and compute eff_addr = use_ptr ? ptr : addr.
    - write=1: commit mem[eff_addr] <= wdata at this edge -> ACK.
    - write=0: -> RD.
    - req=0 and ptr_load=1: ptr <= addr, stay IDLE.
  - RD: read mem[eff_addr] into the output register -> ACK.
  - ACK: ack=1; rdata = read word for reads, 0 for writes. If use_ptr was set, ptr <= ptr+1 (mod depth) and wrap=1 when the old ptr was 2**ADDR_W-1. -> IDLE.
- Latency from the cycle req is sampled high in IDLE: write ack at +1 cycle, read ack at +2 cycles.
- Back-to-back transactions: if req is still high in the cycle after ack, it is a new transaction. Initiators must drop req in the cycle ack is seen.
- req changes while busy are ignored; latched values are used.
- req and ptr_load together in IDLE: req wins, ptr_load is dropped.
- Write then read of the same address: the read returns the new data (the write commits before the read is accepted).
- Pointer arithmetic: ADDR_W-bit unsigned, natural wrap; no saturation.
- Outputs are registered; no combinational path from inputs to outputs; no tri-state.

Decomposition:
- Shared package stim_mem_pkg:
  - state encoding typedef (IDLE/RD/ACK);
  - default DATA_W/ADDR_W constants;
  - RESP_LAT_WR=1 and RESP_LAT_RD=2 constants for the bench.
- One natural sub-module: stim_mem_array, the synchronous word store with async-clear, one write port and one registered read port.
- The FSM and pointer stay in the top level.

Test Plan:
- Reset, then write addr=3 wdata=24'hABCDEF -> ack exactly 1 cycle after req sampled; busy high for 1 cycle; wrap=0.
- Read addr=3 after that write -> ack 2 cycles after req; rdata=24'hABCDEF only in the ack cycle, 0 before and after.
- ptr_load addr=6, then four use_ptr writes of 1,2,3,4 -> writes land at addresses 6,7,0,1; wrap=1 only on the second ack.
- req and ptr_load high together in IDLE with addr=5, write=0 -> read of addr 5 executes; ptr unchanged.
- rst_n pulsed low while in RD -> ack, rdata and busy go 0 immediately; after release, reading any address returns 0.
- Initiator holds req high across ack with write=1, addr=2 -> two back-to-back writes, acks 2 cycles apart, mem[2] holds the final wdata.

Source files
------------

// File: rtl/stim_mem_pkg.sv
// Shared definitions for the stimulus memory responder.
// Holds the FSM state encoding, the default geometry of the word store,
// and the request-to-ack latencies seen by an initiator.
package stim_mem_pkg;

  localparam int DEF_DATA_W  = 24;
  localparam int DEF_ADDR_W  = 3;

  // Cycles from req sampled high in IDLE to the ack pulse
  localparam int RESP_LAT_WR = 1;
  localparam int RESP_LAT_RD = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/stim_mem_array.sv
// Synchronous word store with asynchronous clear.
// Ports:
//   clk, rst_n      - clock and async active-low clear of every word
//   we/waddr/wdata  - single write port, commits on posedge
//   rd_en/raddr     - read request; rd_data is registered and holds the
//                     word for exactly the cycle after rd_en, zero otherwise
module stim_mem_array
  import stim_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Word storage: cleared on reset, one write per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {DATA_W{1'b0}};
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register: returns to zero when not reading so the owner can use
  // it directly as a "valid only during ack" data output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= {DATA_W{1'b0}};
    end else if (rd_en) begin
      rd_data <= mem[raddr];
    end else begin
      rd_data <= {DATA_W{1'b0}};
    end
  end

endmodule

// File: rtl/stim_mem_responder.sv
// Memory-side responder for a single-word req/ack request interface.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   req         - request valid, held until ack
//   write       - 1 = write, 0 = read (sampled with req)
//   use_ptr     - address from the internal pointer instead of addr
//   addr        - request address or pointer load value
//   wdata       - write data (sampled with req)
//   ptr_load    - load pointer from addr when idle and req is low
//   ack         - one-cycle completion pulse
//   rdata       - read data, non-zero only during ack of a read
//   wrap        - pulses with ack when a pointer access wraps max -> 0
//   busy        - high whenever the FSM is not idle
module stim_mem_responder
  import stim_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              write,
  input  logic              use_ptr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              ptr_load,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              wrap,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] PTR_MAX = {ADDR_W{1'b1}};

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] eff_addr;
  logic              lat_use_ptr;

  logic              mem_we;
  logic [ADDR_W-1:0] req_addr;
  logic              rd_en;

  // Address selection and write strobe for the request being sampled now
  always_comb begin
    req_addr = use_ptr ? ptr : addr;
    if (state == ST_IDLE) begin
      mem_we = req & write;
    end else begin
      mem_we = 1'b0;
    end
    rd_en = (state == ST_RD);
  end

  // Writes commit on the accepting edge, so a read issued right after
  // always sees the new word
  stim_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (mem_we),
    .waddr   (req_addr),
    .wdata   (wdata),
    .rd_en   (rd_en),
    .raddr   (eff_addr),
    .rd_data (rdata)
  );

  // Transaction FSM, pointer and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ptr         <= {ADDR_W{1'b0}};
      eff_addr    <= {ADDR_W{1'b0}};
      lat_use_ptr <= 1'b0;
      ack         <= 1'b0;
      wrap        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      ack  <= 1'b0;
      wrap <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            eff_addr    <= req_addr;
            lat_use_ptr <= use_ptr;
            busy        <= 1'b1;
            if (write) begin
              state <= ST_ACK;
              ack   <= 1'b1;
              // pointer cannot move before ack, so wrap is known now
              wrap  <= use_ptr & (ptr == PTR_MAX);
            end else begin
              state <= ST_RD;
            end
          end else if (ptr_load) begin
            ptr  <= addr;
            busy <= 1'b0;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_RD: begin
          state <= ST_ACK;
          ack   <= 1'b1;
          wrap  <= lat_use_ptr & (ptr == PTR_MAX);
          busy  <= 1'b1;
        end
        ST_ACK: begin
          if (lat_use_ptr) begin
            ptr <= ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stim_mem_responder.sv
// Self-checking bench for stim_mem_responder: directed vector table,
// hand-written multi-cycle sequences and randomized traffic compared
// against a simple array/pointer model of the memory.
module tb_stim_mem_responder;
  import stim_mem_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        write;
  logic        use_ptr;
  logic [2:0]  addr;
  logic [23:0] wdata;
  logic        ptr_load;
  logic        ack;
  logic [23:0] rdata;
  logic        wrap;
  logic        busy;

  int checks;
  int failures;

  // model state
  logic [23:0] mmem [8];
  int          mptr;

  typedef struct {
    logic        w;
    logic [2:0]  a;
    logic [23:0] wd;
    logic [23:0] er;
    int          el;
  } vec_t;

  vec_t tbl [9];

  stim_mem_responder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .write    (write),
    .use_ptr  (use_ptr),
    .addr     (addr),
    .wdata    (wdata),
    .ptr_load (ptr_load),
    .ack      (ack),
    .rdata    (rdata),
    .wrap     (wrap),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) mmem[i] = 24'h0;
    mptr = 0;
  endtask

  // Expected result of one transaction from the memory/pointer rules
  task automatic model_step(input logic w, input logic up, input logic [2:0] a,
                            input logic [23:0] wd, output logic [23:0] er,
                            output logic ew, output int el);
    int eff;
    eff = up ? mptr : int'(a);
    ew  = up && (mptr == 7);
    if (w) begin
      mmem[eff] = wd;
      er = 24'h0;
      el = RESP_LAT_WR;
    end else begin
      er = mmem[eff];
      el = RESP_LAT_RD;
    end
    if (up) mptr = (mptr + 1) % 8;
  endtask

  // Drive one request (called just after a posedge with DUT idle) and
  // check latency, data, wrap and busy, then the return to idle
  task automatic transact(input string nm, input logic w, input logic up,
                          input logic [2:0] a, input logic [23:0] wd, input logic pl,
                          input logic [23:0] er, input logic ew, input int el);
    int  cyc;
    bit  got;
    req = 1'b1; write = w; use_ptr = up; addr = a; wdata = wd; ptr_load = pl;
    cyc = 0; got = 0;
    while (!got && cyc < 10) begin
      @(posedge clk); #1;
      ptr_load = 1'b0;
      cyc++;
      if (ack) begin
        got = 1;
      end else begin
        chk({nm, "_rdata_pre"}, 32'(rdata), 32'h0);
        chk({nm, "_busy_pre"}, 32'(busy), 32'h1);
      end
    end
    chk({nm, "_lat"}, 32'(cyc), 32'(el));
    if (got) begin
      chk({nm, "_rdata"}, 32'(rdata), 32'(er));
      chk({nm, "_wrap"}, 32'(wrap), 32'(ew));
      chk({nm, "_busy"}, 32'(busy), 32'h1);
    end
    req = 1'b0;
    @(posedge clk); #1;
    chk({nm, "_ack_post"}, 32'(ack), 32'h0);
    chk({nm, "_rdata_post"}, 32'(rdata), 32'h0);
    chk({nm, "_busy_post"}, 32'(busy), 32'h0);
  endtask

  task automatic mtxn(input string nm, input logic w, input logic up,
                      input logic [2:0] a, input logic [23:0] wd);
    logic [23:0] er;
    logic        ew;
    int          el;
    model_step(w, up, a, wd, er, ew, el);
    transact(nm, w, up, a, wd, 1'b0, er, ew, el);
  endtask

  task automatic load_ptr(input logic [2:0] a);
    req = 1'b0; ptr_load = 1'b1; addr = a;
    @(posedge clk); #1;
    ptr_load = 1'b0;
    chk("ptr_load_busy", 32'(busy), 32'h0);
    mptr = int'(a);
  endtask

  initial begin
    logic [23:0] er;
    logic        ew;
    int          el;
    int          cyc;
    checks = 0; failures = 0;
    rst_n = 1'b0; req = 1'b0; write = 1'b0; use_ptr = 1'b0;
    addr = 3'd0; wdata = 24'h0; ptr_load = 1'b0;
    model_clear();

    tbl[0] = '{1'b1, 3'd3, 24'hABCDEF, 24'h000000, 1};
    tbl[1] = '{1'b0, 3'd3, 24'h000000, 24'hABCDEF, 2};
    tbl[2] = '{1'b1, 3'd0, 24'h123456, 24'h000000, 1};
    tbl[3] = '{1'b0, 3'd0, 24'h000000, 24'h123456, 2};
    tbl[4] = '{1'b0, 3'd3, 24'h000000, 24'hABCDEF, 2};
    tbl[5] = '{1'b1, 3'd7, 24'hFFFFFF, 24'h000000, 1};
    tbl[6] = '{1'b0, 3'd7, 24'h000000, 24'hFFFFFF, 2};
    tbl[7] = '{1'b1, 3'd3, 24'h000001, 24'h000000, 1};
    tbl[8] = '{1'b0, 3'd3, 24'h000000, 24'h000001, 2};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_wrap", 32'(wrap), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // directed table
    for (int i = 0; i < 9; i++) begin
      model_step(tbl[i].w, 1'b0, tbl[i].a, tbl[i].wd, er, ew, el);
      transact($sformatf("tbl%0d", i), tbl[i].w, 1'b0, tbl[i].a, tbl[i].wd, 1'b0,
               tbl[i].er, 1'b0, tbl[i].el);
    end

    // pointer sweep across the wrap point: 6,7,0,1
    load_ptr(3'd6);
    model_step(1'b1, 1'b1, 3'd0, 24'd1, er, ew, el);
    transact("pw1", 1'b1, 1'b1, 3'd0, 24'd1, 1'b0, 24'h0, 1'b0, 1);
    model_step(1'b1, 1'b1, 3'd0, 24'd2, er, ew, el);
    transact("pw2", 1'b1, 1'b1, 3'd5, 24'd2, 1'b0, 24'h0, 1'b1, 1);
    model_step(1'b1, 1'b1, 3'd0, 24'd3, er, ew, el);
    transact("pw3", 1'b1, 1'b1, 3'd0, 24'd3, 1'b0, 24'h0, 1'b0, 1);
    model_step(1'b1, 1'b1, 3'd0, 24'd4, er, ew, el);
    transact("pw4", 1'b1, 1'b1, 3'd0, 24'd4, 1'b0, 24'h0, 1'b0, 1);
    mtxn("pr6", 1'b0, 1'b0, 3'd6, 24'h0);
    chk("pr6_model", 32'(mmem[6]), 32'd1);
    transact("chk6", 1'b0, 1'b0, 3'd6, 24'h0, 1'b0, 24'd1, 1'b0, 2);
    transact("chk7", 1'b0, 1'b0, 3'd7, 24'h0, 1'b0, 24'd2, 1'b0, 2);
    transact("chk0", 1'b0, 1'b0, 3'd0, 24'h0, 1'b0, 24'd3, 1'b0, 2);
    transact("chk1", 1'b0, 1'b0, 3'd1, 24'h0, 1'b0, 24'd4, 1'b0, 2);

    // req wins over ptr_load; pointer (now 2) must be untouched
    mtxn("w5", 1'b1, 1'b0, 3'd5, 24'h555555);
    mtxn("w2", 1'b1, 1'b0, 3'd2, 24'h222222);
    transact("req_pl", 1'b0, 1'b0, 3'd5, 24'h0, 1'b1, 24'h555555, 1'b0, 2);
    model_step(1'b0, 1'b1, 3'd0, 24'h0, er, ew, el);
    transact("ptr_kept", 1'b0, 1'b1, 3'd5, 24'h0, 1'b0, 24'h222222, 1'b0, 2);

    // reset while in RD
    req = 1'b1; write = 1'b0; use_ptr = 1'b0; addr = 3'd3;
    @(posedge clk); #1;
    chk("rd_busy", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ack", 32'(ack), 32'h0);
    chk("arst_rdata", 32'(rdata), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    req = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    model_clear();
    transact("post_rst3", 1'b0, 1'b0, 3'd3, 24'h0, 1'b0, 24'h0, 1'b0, 2);
    transact("post_rst6", 1'b0, 1'b0, 3'd6, 24'h0, 1'b0, 24'h0, 1'b0, 2);

    // back-to-back writes with req held across ack
    req = 1'b1; write = 1'b1; use_ptr = 1'b0; addr = 3'd2; wdata = 24'hAAAAAA;
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!ack && cyc < 10);
    chk("b2b_first_lat", 32'(cyc), 32'd1);
    wdata = 24'hBBBBBB;
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!ack && cyc < 10);
    chk("b2b_gap", 32'(cyc), 32'd2);
    req = 1'b0;
    @(posedge clk); #1;
    mmem[2] = 24'hBBBBBB;
    mtxn("b2b_read", 1'b0, 1'b0, 3'd2, 24'h0);

    // randomized traffic against the model
    for (int i = 0; i < 150; i++) begin
      logic        rw;
      logic        rup;
      logic [2:0]  ra;
      logic [23:0] rwd;
      if ($urandom_range(0, 5) == 0) load_ptr(3'($urandom_range(0, 7)));
      rw  = 1'($urandom_range(0, 1));
      rup = 1'($urandom_range(0, 1));
      ra  = 3'($urandom_range(0, 7));
      rwd = 24'($urandom);
      mtxn($sformatf("rnd%0d", i), rw, rup, ra, rwd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
